// File: rtl/user_uart_rx_pkg.sv
// rtl/user_uart_rx_pkg.sv - shared types and register map for the user_uart_rx receiver
package user_uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   localparam logic [2:0] REG_DATA   = 3'h0;
   localparam logic [2:0] REG_STATUS = 3'h4;

   localparam int BIT_NOT_EMPTY  = 0;
   localparam int BIT_FULL       = 1;
   localparam int BIT_OVERRUN    = 2;
   localparam int BIT_FRAME_ERR  = 3;
   localparam int BIT_PARITY_ERR = 4;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/user_uart_rx_if.sv
// rtl/user_uart_rx_if.sv - naive_bus register-access interface with master/slave views
interface naive_bus;
   logic        rd_req;
   logic        rd_gnt;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        wr_req;
   logic        wr_gnt;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
      input  rd_gnt, rd_data, wr_gnt
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
      output rd_gnt, rd_data, wr_gnt
   );
endinterface

// File: rtl/user_uart_rx_fifo.sv
// rtl/user_uart_rx_fifo.sv - synchronous receive FIFO (uart_rx_fifo), push and pop may coincide
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   // A pop frees the head slot in the same edge, so a full FIFO can still accept
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/user_uart_rx.sv
// rtl/user_uart_rx.sv - naive_bus UART receiver with FIFO; USER_UART_RX_PARITY_EN selects 8E1
module user_uart_rx
   import user_uart_rx_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_uart_rx,
   naive_bus.slave  bus
);
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV) + 1;
   localparam int NW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] HALF_LOAD = CW'(DIV/2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

   rx_state_t     state;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          push, frame_set;
   logic          tick;
   logic          overrun, frame_err, parity_err;
   logic          fifo_full, fifo_empty, pop;
   logic [7:0]    fifo_dout;
   logic [NW-1:0] fifo_count;
   logic [4:2]    clr;
   logic [31:0]   status_word;
   logic          unused_bus_bits;

   assign tick = (baud_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

`ifdef USER_UART_RX_PARITY_EN
   logic parity_bad, parity_set;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         push      <= 1'b0;
         frame_set <= 1'b0;
`ifdef USER_UART_RX_PARITY_EN
         parity_bad <= 1'b0;
         parity_set <= 1'b0;
`endif
      end else begin
         push      <= 1'b0;
         frame_set <= 1'b0;
`ifdef USER_UART_RX_PARITY_EN
         parity_set <= 1'b0;
`endif
         if (state != IDLE && state != BREAK && !tick) baud_cnt <= baud_cnt - 1'b1;
         case (state)
            IDLE: if (rx_prev && !rx_sync) begin
               baud_cnt <= HALF_LOAD;
               state    <= START;
            end
            START: if (tick) begin
               // Line back high at mid start bit: treat as a glitch
               if (!rx_sync) begin
                  baud_cnt <= FULL_LOAD;
                  bit_cnt  <= '0;
                  state    <= DATA;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: if (tick) begin
               shift    <= {rx_sync, shift[7:1]};
               baud_cnt <= FULL_LOAD;
               bit_cnt  <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
`ifdef USER_UART_RX_PARITY_EN
                  state <= PARITY;
`else
                  state <= STOP;
`endif
               end
            end
`ifdef USER_UART_RX_PARITY_EN
            PARITY: if (tick) begin
               parity_bad <= even_parity(shift) ^ rx_sync;
               baud_cnt   <= FULL_LOAD;
               state      <= STOP;
            end
`endif
            STOP: if (tick) begin
`ifdef USER_UART_RX_PARITY_EN
               parity_set <= parity_bad;
               push       <= rx_sync && !parity_bad;
`else
               push       <= rx_sync;
`endif
               if (rx_sync) begin
                  state <= IDLE;
               end else begin
                  frame_set <= 1'b1;
                  state     <= BREAK;
               end
            end
            BREAK: if (rx_sync) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   uart_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (shift),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.rd_gnt = bus.rd_req;
   assign bus.wr_gnt = bus.wr_req;
   assign pop = bus.rd_req && (bus.rd_addr[2:0] == REG_DATA) && !fifo_empty;
   assign clr = (bus.wr_req && bus.wr_addr[2:0] == REG_STATUS && bus.wr_be[0])
                ? bus.wr_data[4:2] : 3'b000;
   assign unused_bus_bits = ^{bus.rd_addr, bus.wr_addr, bus.wr_data, bus.wr_be};

   // Sticky flags: a set in the same cycle as its W1C clear wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= (overrun & ~clr[BIT_OVERRUN]) | (push && fifo_full && !pop);
         frame_err <= (frame_err & ~clr[BIT_FRAME_ERR]) | frame_set;
      end
   end

`ifdef USER_UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err <= 1'b0;
      else        parity_err <= (parity_err & ~clr[BIT_PARITY_ERR]) | parity_set;
   end
`else
   assign parity_err = 1'b0;
`endif

   always_comb begin
      status_word                 = '0;
      status_word[15:8]           = 8'(fifo_count);
      status_word[BIT_PARITY_ERR] = parity_err;
      status_word[BIT_FRAME_ERR]  = frame_err;
      status_word[BIT_OVERRUN]    = overrun;
      status_word[BIT_FULL]       = fifo_full;
      status_word[BIT_NOT_EMPTY]  = !fifo_empty;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data <= '0;
      end else if (bus.rd_req) begin
         case (bus.rd_addr[2:0])
            REG_DATA:   bus.rd_data <= fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_dout};
            REG_STATUS: bus.rd_data <= status_word;
            default:    bus.rd_data <= 32'h0;
         endcase
      end
   end
endmodule

// File: tb/tb_user_uart_rx.sv
// tb/tb_user_uart_rx.sv - directed self-checking bench for user_uart_rx
module tb_user_uart_rx;
   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 1_562_500;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam logic [31:0] A_DATA   = 32'h0004_0000;
   localparam logic [31:0] A_STATUS = 32'h0004_0004;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] rd;

   naive_bus bus();

   user_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_uart_rx (rx),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef USER_UART_RX_PARITY_EN
      bit_time((^d) ^ par_flip);
`else
      if (par_flip) rx = 1'b1;
`endif
      bit_time(stop);
      rx = 1'b1;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      bus.rd_req  = 1'b1;
      bus.rd_addr = addr;
      @(negedge clk);
      bus.rd_req  = 1'b0;
      data = bus.rd_data;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus.wr_req  = 1'b1;
      bus.wr_addr = addr;
      bus.wr_data = data;
      bus.wr_be   = be;
      @(negedge clk);
      bus.wr_req  = 1'b0;
   endtask

   initial begin
      bus.rd_req = 1'b0; bus.rd_addr = '0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      check("reset_rd_data", bus.rd_data, 32'h0);
      bus_read(A_STATUS, rd); check("reset_status", rd, 32'h0);

      // 1: single byte then empty read
      send_frame(8'h55, 1'b1, 1'b0);
      bus_read(A_STATUS, rd); check("t1_status", rd, 32'h0101);
      bus_read(A_DATA, rd);   check("t1_data", rd, 32'h155);
      bus_read(A_DATA, rd);   check("t1_empty_data", rd, 32'h0);
      bus_read(A_STATUS, rd); check("t1_status_empty", rd, 32'h0);

      // 2: overflow by one
      for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
      bus_read(A_STATUS, rd); check("t2_status_full", rd, 32'h1007);
      for (int i = 0; i < 16; i++) begin
         bus_read(A_DATA, rd);
         check($sformatf("t2_data%0d", i), rd, 32'h100 + 32'(i));
      end
      bus_read(A_STATUS, rd); check("t2_status_drained", rd, 32'h0004);
      bus_write(A_STATUS, 32'h04, 4'b0001);
      bus_read(A_STATUS, rd); check("t2_status_cleared", rd, 32'h0);

      // 3: short glitch then a real byte
      rx = 1'b0; repeat (DIV/2 - 6) @(negedge clk);
      rx = 1'b1; repeat (3*DIV) @(negedge clk);
      bus_read(A_STATUS, rd); check("t3_glitch_status", rd, 32'h0);
      send_frame(8'h3C, 1'b1, 1'b0);
      bus_read(A_DATA, rd);   check("t3_data", rd, 32'h13C);

      // 4: framing error, write without byte-lane 0 must not clear
      send_frame(8'hA5, 1'b0, 1'b0);
      repeat (DIV) @(negedge clk);
      bus_read(A_STATUS, rd); check("t4_frame_err", rd, 32'h0008);
      bus_write(A_STATUS, 32'h08, 4'b0010);
      bus_read(A_STATUS, rd); check("t4_no_be0", rd, 32'h0008);
      bus_write(A_DATA, 32'h08, 4'b0001);
      bus_read(A_STATUS, rd); check("t4_data_write", rd, 32'h0008);
      bus_write(A_STATUS, 32'h08, 4'b0001);
      bus_read(A_STATUS, rd); check("t4_cleared", rd, 32'h0);

      // 5: pop in the same cycle as a push
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0);
      bus_read(A_STATUS, rd); check("t5_preload", rd, 32'h0301);
      fork
         send_frame(8'h44, 1'b1, 1'b0);
         begin : catch_push
            int n;
            n = 0;
            while (!dut.push && n < 12*DIV) begin
               @(negedge clk);
               n++;
            end
            check("t5_push_seen", 32'(dut.push), 32'h1);
            bus_read(A_DATA, rd); check("t5_coincident_pop", rd, 32'h111);
         end
      join
      bus_read(A_STATUS, rd); check("t5_count_kept", rd, 32'h0301);
      bus_read(A_DATA, rd);   check("t5_b2", rd, 32'h122);
      bus_read(A_DATA, rd);   check("t5_b3", rd, 32'h133);
      bus_read(A_DATA, rd);   check("t5_b4", rd, 32'h144);

      // 6: reset mid-byte (0xF5, reset during bit 4 which is high)
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(i[0] ? 1'b0 : 1'b1);
      rx = 1'b1;
      repeat (DIV/2) @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (DIV/2 + 4*DIV) @(negedge clk);
      check("t6_rd_data_reset", bus.rd_data, 32'h0);
      bus_read(A_STATUS, rd); check("t6_status", rd, 32'h0);
      send_frame(8'h7E, 1'b1, 1'b0);
      bus_read(A_DATA, rd);   check("t6_data", rd, 32'h17E);
      bus_read(A_STATUS, rd); check("t6_status_after", rd, 32'h0);

`ifdef USER_UART_RX_PARITY_EN
      send_frame(8'h01, 1'b1, 1'b1);
      bus_read(A_STATUS, rd); check("par_err", rd, 32'h0010);
      bus_write(A_STATUS, 32'h10, 4'b0001);
      bus_read(A_STATUS, rd); check("par_cleared", rd, 32'h0);
`else
      bus_write(A_STATUS, 32'h10, 4'b0001);
      bus_read(A_STATUS, rd); check("par_bit_zero", rd, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
